// File: rtl/npu_conv_seq.sv
// Convolution sequencer: streams weights, then slides a K_SIZE-wide window over the
// activation columns through the word buffer read port, drains the PE and pulses done.
module npu_conv_seq #(
    parameter int N            = 10,
    parameter int K_SIZE       = 3,
    parameter int PE_LAT       = 4,
    parameter int BUFFER_DEPTH = (N + 1) * K_SIZE,
    parameter int AW           = $clog2(BUFFER_DEPTH),
    parameter int CW           = $clog2(BUFFER_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic [CW-1:0] cfg_cols_i,
    input  logic          pe_ready_i,
    output logic          buf_ren_o,
    output logic [AW-1:0] buf_raddr_o,
    output logic          pe_wload_o,
    output logic          pe_valid_o,
    output logic          pe_first_o,
    output logic          pe_last_o,
    output logic [CW-1:0] out_idx_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);
    localparam int KW = (K_SIZE > 1) ? $clog2(K_SIZE) : 1;
    localparam int DW = (PE_LAT > 0) ? $clog2(PE_LAT + 1) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOADW = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cols_q, cols_d;
    logic [CW-1:0] o_q, o_d;
    logic [KW-1:0] k_q, k_d;
    logic [DW-1:0] d_q, d_d;
    logic          err_q, err_d;
    logic          valid_q, wload_q, first_q, last_q;
    logic [CW-1:0] idx_q;

    logic in_loadw, in_run, in_drain, issuing, k_last, o_last, cfg_ok;

    assign in_loadw = (state_q == S_LOADW);
    assign in_run   = (state_q == S_RUN);
    assign in_drain = (state_q == S_DRAIN);
    // Abort suppresses the read in the very cycle it is raised.
    assign issuing  = (in_loadw || in_run) && pe_ready_i && !abort_i;
    assign k_last   = (k_q == KW'(K_SIZE - 1));
    assign o_last   = (o_q == cols_q - CW'(K_SIZE));
    assign cfg_ok   = (cfg_cols_i >= CW'(K_SIZE)) && (cfg_cols_i <= CW'(N * K_SIZE));

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path infers a latch.
        state_d = state_q;
        cols_d  = cols_q;
        o_d     = o_q;
        k_d     = k_q;
        d_d     = d_q;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    if (cfg_ok) begin
                        cols_d  = cfg_cols_i;
                        o_d     = '0;
                        k_d     = '0;
                        d_d     = '0;
                        state_d = S_LOADW;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOADW: begin
                if (issuing) begin
                    if (k_last) begin
                        k_d     = '0;
                        o_d     = '0;
                        state_d = S_RUN;
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_RUN: begin
                if (issuing) begin
                    if (k_last) begin
                        k_d = '0;
                        if (o_last) begin
                            d_d     = '0;
                            state_d = S_DRAIN;
                        end else begin
                            o_d = o_q + CW'(1);
                        end
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (d_q == DW'(PE_LAT)) state_d = S_DONE;
                else                    d_d     = d_q + DW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && (in_loadw || in_run || in_drain)) begin
            state_d = S_IDLE;
            o_d     = '0;
            k_d     = '0;
            d_d     = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cols_q  <= '0;
            o_q     <= '0;
            k_q     <= '0;
            d_q     <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            wload_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cols_q  <= cols_d;
            o_q     <= o_d;
            k_q     <= k_d;
            d_q     <= d_d;
            err_q   <= err_d;
            // Sideband lines up with buffer rdata, one cycle after the read strobe.
            valid_q <= issuing;
            wload_q <= issuing && in_loadw;
            first_q <= issuing && in_run && (k_q == '0);
            last_q  <= issuing && in_run && k_last;
            idx_q   <= (issuing && in_run) ? o_q : '0;
        end
    end

    always_comb begin
        buf_raddr_o = '0;
        if (in_loadw)    buf_raddr_o = AW'(k_q);
        else if (in_run) buf_raddr_o = AW'(K_SIZE) + AW'(o_q) + AW'(k_q);
    end

    assign buf_ren_o  = issuing;
    assign pe_valid_o = valid_q;
    assign pe_wload_o = wload_q;
    assign pe_first_o = first_q;
    assign pe_last_o  = last_q;
    assign out_idx_o  = idx_q;
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = err_q;

endmodule

// File: tb/tb_npu_conv_seq.sv
// Scoreboard bench for npu_conv_seq: an issue queue checks read strobes/addresses and
// a beat queue checks the registered sideband one cycle later.
module tb_npu_conv_seq;
    localparam int N      = 10;
    localparam int K      = 3;
    localparam int PE_LAT = 4;
    localparam int AW     = 6;
    localparam int CW     = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_i = 1'b0;
    logic          abort_i = 1'b0;
    logic [CW-1:0] cfg_cols_i = '0;
    logic          pe_ready_i = 1'b0;
    logic          buf_ren_o;
    logic [AW-1:0] buf_raddr_o;
    logic          pe_wload_o, pe_valid_o, pe_first_o, pe_last_o;
    logic [CW-1:0] out_idx_o;
    logic          busy_o, done_o, err_o;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          wload;
        logic          first;
        logic          last;
        logic [CW-1:0] idx;
    } beat_t;

    beat_t issue_q[$];
    beat_t beat_q[$];

    always #5 clk = ~clk;

    npu_conv_seq #(.N(N), .K_SIZE(K), .PE_LAT(PE_LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .cfg_cols_i (cfg_cols_i),
        .pe_ready_i (pe_ready_i),
        .buf_ren_o  (buf_ren_o),
        .buf_raddr_o(buf_raddr_o),
        .pe_wload_o (pe_wload_o),
        .pe_valid_o (pe_valid_o),
        .pe_first_o (pe_first_o),
        .pe_last_o  (pe_last_o),
        .out_idx_o  (out_idx_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    // Runs one job. abort_at>0 raises abort when that many reads have been issued;
    // busy_start_cyc>0 re-pulses start in that cycle while the job is in flight.
    task automatic run_job(input string name, input int cols, input bit bp,
                           input int abort_at, input int busy_start_cyc);
        beat_t e;
        beat_t b;
        int    n_reads, done_cyc, end_cyc, issued, ren_cnt;
        bit    exp_ren, prev_exp_ren, exp_busy, aborted;
        issue_q.delete();
        beat_q.delete();
        for (int k = 0; k < K; k++) begin
            e.addr = AW'(k); e.wload = 1'b1; e.first = 1'b0; e.last = 1'b0; e.idx = '0;
            issue_q.push_back(e);
        end
        for (int o = 0; o <= cols - K; o++) begin
            for (int k = 0; k < K; k++) begin
                e.addr  = AW'(K + o + k);
                e.wload = 1'b0;
                e.first = (k == 0);
                e.last  = (k == K - 1);
                e.idx   = CW'(o);
                issue_q.push_back(e);
            end
        end
        n_reads      = issue_q.size();
        done_cyc     = -1;
        end_cyc      = 400;
        issued       = 0;
        ren_cnt      = 0;
        prev_exp_ren = 1'b0;
        aborted      = 1'b0;

        @(negedge clk);
        start_i    = 1'b1;
        cfg_cols_i = CW'(cols);
        for (int cyc = 1; cyc <= end_cyc; cyc++) begin
            @(posedge clk);
            #1;
            start_i = (cyc == busy_start_cyc);
            if (start_i) cfg_cols_i = CW'(K);
            pe_ready_i = bp ? (cyc % 3 != 0) : 1'b1;
            abort_i    = (abort_at > 0) && !aborted && (issued == abort_at);
            @(negedge clk);

            exp_ren  = pe_ready_i && !abort_i && !aborted && (issue_q.size() > 0);
            exp_busy = !aborted && (done_cyc < 0 || cyc <= done_cyc);
            if (buf_ren_o) ren_cnt++;

            checks++;
            if (buf_ren_o !== exp_ren) begin
                errors++;
                $display("FAIL %s ren cyc%0d: got %b want %b", name, cyc, buf_ren_o, exp_ren);
            end
            if (exp_ren) begin
                e = issue_q.pop_front();
                issued++;
                checks++;
                if (buf_raddr_o !== e.addr) begin
                    errors++;
                    $display("FAIL %s raddr cyc%0d: got %0d want %0d", name, cyc, buf_raddr_o, e.addr);
                end
                beat_q.push_back(e);
                if (issue_q.size() == 0) begin
                    done_cyc = cyc + 2 + PE_LAT;
                    end_cyc  = done_cyc + 2;
                end
            end

            checks++;
            if (pe_valid_o !== prev_exp_ren) begin
                errors++;
                $display("FAIL %s valid cyc%0d: got %b want %b", name, cyc, pe_valid_o, prev_exp_ren);
            end
            if (prev_exp_ren) begin
                b = beat_q.pop_front();
                checks++;
                if ({pe_wload_o, pe_first_o, pe_last_o, out_idx_o} !== {b.wload, b.first, b.last, b.idx}) begin
                    errors++;
                    $display("FAIL %s beat cyc%0d: got w%b f%b l%b idx%0d want w%b f%b l%b idx%0d",
                             name, cyc, pe_wload_o, pe_first_o, pe_last_o, out_idx_o,
                             b.wload, b.first, b.last, b.idx);
                end
            end
            prev_exp_ren = exp_ren;

            checks++;
            if (done_o !== (cyc == done_cyc)) begin
                errors++;
                $display("FAIL %s done cyc%0d: got %b want %b", name, cyc, done_o, cyc == done_cyc);
            end
            checks++;
            if (busy_o !== exp_busy) begin
                errors++;
                $display("FAIL %s busy cyc%0d: got %b want %b", name, cyc, busy_o, exp_busy);
            end
            checks++;
            if (err_o !== 1'b0) begin
                errors++;
                $display("FAIL %s err cyc%0d: got %b want 0", name, cyc, err_o);
            end
            if (abort_i) begin
                aborted = 1'b1;
                end_cyc = cyc + 3;
            end
        end
        start_i    = 1'b0;
        abort_i    = 1'b0;
        pe_ready_i = 1'b0;

        checks++;
        if (ren_cnt != ((abort_at > 0) ? abort_at : n_reads)) begin
            errors++;
            $display("FAIL %s read_count: got %0d want %0d", name, ren_cnt,
                     (abort_at > 0) ? abort_at : n_reads);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({buf_ren_o, buf_raddr_o, pe_wload_o, pe_valid_o, pe_first_o, pe_last_o,
             out_idx_o, busy_o, done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got ren%b addr%0d busy%b done%b err%b want all 0",
                     buf_ren_o, buf_raddr_o, busy_o, done_o, err_o);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", busy_o);
        end
    endtask

    task automatic test_nominal();
        run_job("nominal", 10, 1'b0, 0, 0);
    endtask

    task automatic test_backpressure();
        run_job("backpressure", 10, 1'b1, 0, 0);
    endtask

    task automatic test_bounds();
        int bad_cols[2] = '{2, 31};
        foreach (bad_cols[i]) begin
            @(negedge clk);
            start_i    = 1'b1;
            cfg_cols_i = CW'(bad_cols[i]);
            pe_ready_i = 1'b1;
            @(posedge clk);
            #1 start_i = 1'b0;
            @(negedge clk);
            checks++;
            if ({err_o, busy_o, buf_ren_o} !== 3'b100) begin
                errors++;
                $display("FAIL bounds_reject cols=%0d: got err%b busy%b ren%b want err1 busy0 ren0",
                         bad_cols[i], err_o, busy_o, buf_ren_o);
            end
            @(negedge clk);
            checks++;
            if ({err_o, busy_o, buf_ren_o} !== 3'b000) begin
                errors++;
                $display("FAIL bounds_after cols=%0d: got err%b busy%b ren%b want 000",
                         bad_cols[i], err_o, busy_o, buf_ren_o);
            end
        end
        // Abort wins over a simultaneous start in IDLE.
        @(negedge clk);
        start_i    = 1'b1;
        abort_i    = 1'b1;
        cfg_cols_i = CW'(10);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        abort_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy_o, buf_ren_o, err_o} !== 3'b000) begin
            errors++;
            $display("FAIL abort_beats_start: got busy%b ren%b err%b want 000", busy_o, buf_ren_o, err_o);
        end
        pe_ready_i = 1'b0;
        run_job("cols3", 3, 1'b0, 0, 0);
        run_job("cols30", 30, 1'b0, 0, 0);
    endtask

    task automatic test_abort();
        run_job("abort", 10, 1'b0, K + 9, 0);
        run_job("after_abort", 10, 1'b0, 0, 0);
    endtask

    task automatic test_start_busy();
        run_job("start_busy", 10, 1'b0, 0, 5);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start_i    = 1'b1;
        cfg_cols_i = CW'(10);
        pe_ready_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({buf_ren_o, buf_raddr_o, pe_wload_o, pe_valid_o, pe_first_o, pe_last_o,
             out_idx_o, busy_o, done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_run: got ren%b addr%0d valid%b idx%0d busy%b want all 0",
                     buf_ren_o, buf_raddr_o, pe_valid_o, out_idx_o, busy_o);
        end
        @(negedge clk);
        reset      = 1'b0;
        pe_ready_i = 1'b0;
        run_job("after_reset", 10, 1'b0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_bounds();
        test_abort();
        test_start_busy();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
